// File: rtl/dense_result_serializer.sv
// dense_result_serializer
// Captures the dense layer's parallel result vector, applies optional ReLU,
// saturates each element to OUT_W signed bits and streams the elements out
// one per beat on a valid/ready interface. All outputs are registered.
//
// Build option: define DENSE_RELU_EN to clamp negative elements to zero
// before saturation. Without it, elements are saturated as signed values.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for a vector; in_ready=1 (after first edge out of reset)
// S_STREAM| presenting buf[idx] on the output port; out_valid=1
module dense_result_serializer #(
  parameter int N_OUT = 5,
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_result [0:N_OUT-1],
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic [IDX_W-1:0]        out_index,
  output logic                    out_last,
  output logic                    out_sat
);

  typedef enum logic {S_IDLE = 1'b0, S_STREAM = 1'b1} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OUT - 1);

  // Saturation limits expressed at input width so comparisons stay signed.
  localparam logic signed [IN_W-1:0] SAT_MAX =
    {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] SAT_MIN =
    {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic signed [IN_W-1:0]   buf_q [0:N_OUT-1];
  logic                     capture;

  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0]  out_data_q, out_data_d;
  logic [IDX_W-1:0]         out_index_q, out_index_d;
  logic                     out_last_q, out_last_d;
  logic                     out_sat_q, out_sat_d;

  // Returns {clamped, value}: optional ReLU, then signed saturation.
  function automatic logic [OUT_W:0] proc(input logic signed [IN_W-1:0] x);
    logic signed [IN_W-1:0] v;
    logic [OUT_W:0]         r;
    v = x;
`ifdef DENSE_RELU_EN
    if (v[IN_W-1]) v = '0;
`endif
    if (v > SAT_MAX)      r = {1'b1, SAT_MAX[OUT_W-1:0]};
    else if (v < SAT_MIN) r = {1'b1, SAT_MIN[OUT_W-1:0]};
    else                  r = {1'b0, v[OUT_W-1:0]};
    return r;
  endfunction

  // State, index and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
      out_sat_q   <= out_sat_d;
    end
  end

  // Vector buffer: written only on the capture edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_OUT; i++) buf_q[i] <= '0;
    end else if (capture) begin
      for (int i = 0; i < N_OUT; i++) buf_q[i] <= in_result[i];
    end
  end

  // Next state and next registered outputs. The output registers are loaded
  // with the element that will be presented next, so out_data is already
  // valid in the cycle after capture/advance.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    capture     = 1'b0;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    out_last_d  = out_last_q;
    out_sat_d   = out_sat_q;
    case (state_q)
      S_IDLE: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        if (in_valid && in_ready_q) begin
          capture                 = 1'b1;
          state_d                 = S_STREAM;
          idx_d                   = '0;
          in_ready_d              = 1'b0;
          out_valid_d             = 1'b1;
          {out_sat_d, out_data_d} = proc(in_result[0]);
          out_index_d             = '0;
          out_last_d              = (LAST_IDX == '0);
        end
      end
      S_STREAM: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d     = S_IDLE;
            idx_d       = '0;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_index_d = '0;
            out_last_d  = 1'b0;
            out_sat_d   = 1'b0;
          end else begin
            idx_d                   = idx_q + 1'b1;
            out_valid_d             = 1'b1;
            {out_sat_d, out_data_d} = proc(buf_q[idx_d]);
            out_index_d             = idx_d;
            out_last_d              = (idx_d == LAST_IDX);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign out_last  = out_last_q;
  assign out_sat   = out_sat_q;

endmodule
